// File: rtl/compute_sequencer.sv
// Program sequencer: buffers 16-bit instruction words and issues them to the compute unit over valid/ready.
// Optional macro SEQ_SKIP_NOP_EN: opcode 4'b0000 words are skipped instead of presented.
module compute_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [3:0]        loop_cnt,
  input  logic              start,
  input  logic              stop,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [7:0]        result_in,
  output logic [7:0]        last_result,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [7:0]        issue_cnt,
  output logic [1:0]        state_dbg
);

  // Handshake: a word transfers on a cycle where instr_valid and instr_ready are
  // both high; valid never depends on ready and holds with instr_out until taken.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [15:0]     mem [DEPTH];
  state_t          state;
  logic [ADDR_W:0] len_r;
  logic [3:0]      loop_rem;
  logic            cap_pend;
  logic            is_nop;
  logic            xfer;
  logic            advance;
  logic            at_end;
  logic [ADDR_W:0] len_cap;

  assign instr_out = mem[pc];

`ifdef SEQ_SKIP_NOP_EN
  assign is_nop = (instr_out[15:12] == 4'b0000);
`else
  assign is_nop = 1'b0;
`endif

  assign instr_valid = ena && (state == RUN) && !is_nop;
  assign xfer        = instr_valid && instr_ready;
  assign advance     = xfer || (ena && (state == RUN) && is_nop);
  assign at_end      = ({1'b0, pc} == (len_r - 1'b1));
  assign busy        = (state != IDLE);
  assign state_dbg   = state;
  assign len_cap     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

  // Buffer is deliberately left out of reset so a program survives a sequencer reset.
  always_ff @(posedge clk) begin
    if (rst_n && ena && prog_we && (state == IDLE))
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      loop_rem    <= '0;
      len_r       <= '0;
      last_result <= '0;
      issue_cnt   <= '0;
      done        <= 1'b0;
      cap_pend    <= 1'b0;
    end else if (ena) begin
      done     <= 1'b0;
      cap_pend <= xfer;
      // The unit registers its result, so it is valid one cycle after acceptance.
      if (cap_pend)
        last_result <= result_in;
      if (xfer)
        issue_cnt <= issue_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (start && (prog_len != '0)) begin
            len_r     <= len_cap;
            loop_rem  <= loop_cnt;
            pc        <= '0;
            issue_cnt <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            if (at_end) begin
              if (loop_rem != 4'd0) begin
                pc       <= '0;
                loop_rem <= loop_rem - 4'd1;
              end
            end else begin
              pc <= pc + 1'b1;
            end
          end
          if (stop) begin
            state <= IDLE;
          end else if (advance && at_end && (loop_rem == 4'd0)) begin
            state <= DONE_S;
            done  <= 1'b1;
          end
        end
        DONE_S: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compute_sequencer.sv
// Directed bench for compute_sequencer: expected {pc, word} pairs are queued by the stimulus
// and popped by a monitor on every accepted transfer; counters and results are checked directly.
module tb_compute_sequencer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int EW     = ADDR_W + 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [ADDR_W:0]   prog_len;
  logic [3:0]        loop_cnt;
  logic              start;
  logic              stop;
  logic [15:0]       instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        result_in;
  logic [7:0]        last_result;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic [7:0]        issue_cnt;
  logic [1:0]        state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int valid_cyc = 0;
  int base_valid;
  int base_done;

  compute_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .loop_cnt(loop_cnt), .start(start),
    .stop(stop), .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .result_in(result_in), .last_result(last_result), .pc(pc), .busy(busy), .done(done),
    .issue_cnt(issue_cnt), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Compute unit stand-in: result appears one cycle after acceptance
  function automatic logic [7:0] unit_result(input logic [15:0] w);
    return (w == 16'hA312) ? 8'h08 : w[7:0];
  endfunction

  initial begin
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        v = unit_result(instr_out);
        @(posedge clk);
        #1 result_in = v;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (instr_valid) valid_cyc++;
      if (instr_valid && instr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL transfer: unexpected pc=%0d word=%h, expected none", pc, instr_out);
        end else begin
          e = exp_q.pop_front();
          if ({pc, instr_out} !== e) begin
            failures++;
            $display("FAIL transfer: got pc=%0d word=%h, expected pc=%0d word=%h",
                     pc, instr_out, e[EW-1:16], e[15:0]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start_prog(input logic [ADDR_W:0] len, input logic [3:0] loops);
    prog_len = len; loop_cnt = loops; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_word(input int a, input logic [15:0] w);
    exp_q.push_back({ADDR_W'(a), w});
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && busy; i++) tick();
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; loop_cnt = '0; start = 1'b0; stop = 1'b0; instr_ready = 1'b1;
    result_in = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;

    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset pc", {29'd0, pc}, 32'd0);
    check("reset issue_cnt", {24'd0, issue_cnt}, 32'd0);
    check("reset last_result", {24'd0, last_result}, 32'd0);
    check("reset valid", {31'd0, instr_valid}, 32'd0);

    write_word(3'd0, 16'h9105);
    write_word(3'd1, 16'h9203);
    write_word(3'd2, 16'hA312);
    write_word(3'd3, 16'h9404);

    // Basic three-word program
    base_valid = valid_cyc; base_done = done_cnt;
    expect_word(0, 16'h9105); expect_word(1, 16'h9203); expect_word(2, 16'hA312);
    start_prog(4'd3, 4'd0);
    check("first valid latency", {31'd0, instr_valid}, 32'd1);
    wait_idle("basic timeout");
    check("basic valid cycles", valid_cyc - base_valid, 32'd3);
    check("basic done pulses", done_cnt - base_done, 32'd1);
    check("basic issue_cnt", {24'd0, issue_cnt}, 32'd3);
    check("basic last_result", {24'd0, last_result}, 32'h08);

    // Stall two cycles at pc=1
    base_valid = valid_cyc;
    expect_word(0, 16'h9105); expect_word(1, 16'h9203); expect_word(2, 16'hA312);
    start_prog(4'd3, 4'd0);
    tick();
    instr_ready = 1'b0;
    tick();
    check("stall hold word", {16'd0, instr_out}, 32'h9203);
    tick();
    check("stall hold valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    wait_idle("stall timeout");
    check("stall valid cycles", valid_cyc - base_valid, 32'd5);
    check("stall issue_cnt", {24'd0, issue_cnt}, 32'd3);

    // ena low mid-run, and a write attempted while busy
    expect_word(0, 16'h9105); expect_word(1, 16'h9203); expect_word(2, 16'hA312);
    start_prog(4'd3, 4'd0);
    tick();
    ena = 1'b0; prog_we = 1'b1; prog_addr = 3'd2; prog_data = 16'hFFFF;
    #2;
    check("ena low valid", {31'd0, instr_valid}, 32'd0);
    check("ena low pc", {29'd0, pc}, 32'd1);
    tick();
    ena = 1'b1;
    tick();
    prog_we = 1'b0;
    wait_idle("ena timeout");
    check("ena issue_cnt", {24'd0, issue_cnt}, 32'd3);

    // Looping: two words, three passes
    base_done = done_cnt;
    for (int p = 0; p < 3; p++) begin
      expect_word(0, 16'h9105); expect_word(1, 16'h9203);
    end
    start_prog(4'd2, 4'd2);
    wait_idle("loop timeout");
    check("loop issue_cnt", {24'd0, issue_cnt}, 32'd6);
    check("loop done pulses", done_cnt - base_done, 32'd1);
    check("loop last_result", {24'd0, last_result}, 32'h03);

    // Stop in the cycle of the second transfer
    base_done = done_cnt;
    expect_word(0, 16'h9105); expect_word(1, 16'h9203);
    start_prog(4'd4, 4'd0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop busy", {31'd0, busy}, 32'd0);
    check("stop pc", {29'd0, pc}, 32'd2);
    check("stop issue_cnt", {24'd0, issue_cnt}, 32'd2);
    tick();
    check("stop last_result", {24'd0, last_result}, 32'h03);
    check("stop no done", done_cnt - base_done, 32'd0);

    // Zero-length start is ignored
    base_valid = valid_cyc;
    start_prog(4'd0, 4'd0);
    tick();
    check("len0 busy", {31'd0, busy}, 32'd0);
    check("len0 valid cycles", valid_cyc - base_valid, 32'd0);

    // Write and start in the same cycle
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = 16'h9111;
    expect_word(0, 16'h9111);
    start_prog(4'd1, 4'd0);
    prog_we = 1'b0;
    wait_idle("wstart timeout");
    check("wstart issue_cnt", {24'd0, issue_cnt}, 32'd1);
    write_word(3'd0, 16'h9105);

    // Reset mid-run
    expect_word(0, 16'h9105); expect_word(1, 16'h9203);
    start_prog(4'd3, 4'd0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset issue_cnt", {24'd0, issue_cnt}, 32'd0);
    check("midreset last_result", {24'd0, last_result}, 32'd0);
    check("midreset pc", {29'd0, pc}, 32'd0);

`ifdef SEQ_SKIP_NOP_EN
    write_word(3'd1, 16'h0000);
    expect_word(0, 16'h9105); expect_word(2, 16'hA312);
    start_prog(4'd3, 4'd0);
    wait_idle("nop timeout");
    check("nop issue_cnt", {24'd0, issue_cnt}, 32'd2);
    write_word(3'd1, 16'h9203);
`endif

    repeat (3) tick();
    check("queue drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
